multicycle_alu: RTL and testbench

//   Parametrised, registered ALU with start/done handshake; successor to the 8-bit combinational ALU.

---
 rtl/multicycle_alu.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//   Registered ALU with a start/done handshake. FWD/ADD/AND/OR/SUB finish in a
//   single cycle. SLL/SRA shift one bit per cycle, and MUL is an unsigned
//   shift-add multiplier that runs for WIDTH cycles. RESULT and the flags are
//   updated only when the FSM enters FIN, and they hold until the next FIN.
//
// Ports
//   clk       in   1      clock, all state changes on posedge
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request, sampled only while not in RUN
//   select    in   3      opcode, latched on acceptance
//   data1     in   WIDTH  operand A, latched on acceptance
//   data2     in   WIDTH  operand B or shift amount, latched on acceptance
//   busy      out  1      high in RUN and FIN (after acceptance up to DONE)
//   done      out  1      one-cycle pulse in FIN
//   result    out  WIDTH  registered result
//   zero      out  1      result == 0
//   carry     out  1      ADD carry out; SUB 1 = no borrow; else 0
//   overflow  out  1      ADD/SUB signed overflow; MUL upper half != 0
// -----------------------------------------------------------------------------
module multicycle_alu #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   state_t               state, state_nxt;
   logic [2:0]           op_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [2*WIDTH-1:0]   acc, acc_step;
   logic [CNT_W-1:0]     cnt, shamt;
   logic [WIDTH:0]       mul_sum, add_full, sub_full;
   logic [WIDTH-1:0]     quick_res;
   logic                 quick_c, quick_v;
   logic                 accept, multi_start, last_step;

   // Requests are taken in IDLE and in FIN, which allows back-to-back ops.
   assign accept = start && (state != RUN);

   // Shift count saturates at WIDTH; B is unsigned.
   assign shamt = (data2 >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : data2[CNT_W-1:0];

   // A zero-length shift is a single-cycle op.
   assign multi_start = accept &&
                        ((select == OP_MUL) ||
                         (((select == OP_SLL) || (select == OP_SRA)) && (shamt != '0)));

   assign last_step = (state == RUN) && (cnt == CNT_W'(1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = multi_start ? RUN : FIN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = FIN;
         end
         FIN: begin
            busy = 1'b1;
            done = 1'b1;
            if (accept) state_nxt = multi_start ? RUN : FIN;
            else        state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- single-cycle results ----------------
   always_comb begin
      add_full  = {1'b0, data1} + {1'b0, data2};
      // A + ~B + 1: the top bit is the "no borrow" carry.
      sub_full  = {1'b0, data1} + {1'b0, ~data2} + (WIDTH+1)'(1);
      quick_res = '0;
      quick_c   = 1'b0;
      quick_v   = 1'b0;
      case (select)
         OP_FWD: quick_res = data2;
         OP_ADD: begin
            quick_res = add_full[WIDTH-1:0];
            quick_c   = add_full[WIDTH];
            quick_v   = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                        (add_full[WIDTH-1] != data1[WIDTH-1]);
         end
         OP_AND: quick_res = data1 & data2;
         OP_OR:  quick_res = data1 | data2;
         OP_SUB: begin
            quick_res = sub_full[WIDTH-1:0];
            quick_c   = sub_full[WIDTH];
            quick_v   = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                        (sub_full[WIDTH-1] != data1[WIDTH-1]);
         end
         OP_SLL, OP_SRA: quick_res = data1;   // only reached with n = 0
         default:        quick_res = '0;      // MUL never completes here
      endcase
   end

   // ---------------- iterative step ----------------
   // MUL: acc = {partial product, remaining multiplier bits}; add the
   // multiplicand to the upper half when the multiplier LSB is set, then
   // shift everything right by one.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : '0);
      acc_step = acc;
      case (op_q)
         OP_SLL:  acc_step[WIDTH-1:0] = {acc[WIDTH-2:0], 1'b0};
         OP_SRA:  acc_step[WIDTH-1:0] = {acc[WIDTH-1], acc[WIDTH-1:1]};
         OP_MUL:  acc_step = {mul_sum, acc[WIDTH-1:1]};
         default: acc_step = acc;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         op_q     <= '0;
         mcand_q  <= '0;
         acc      <= '0;
         cnt      <= '0;
         result   <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         op_q    <= select;
         mcand_q <= data1;
         cnt     <= (select == OP_MUL) ? CNT_W'(WIDTH) : shamt;
         acc     <= (select == OP_MUL) ? {{WIDTH{1'b0}}, data2}
                                       : {{WIDTH{1'b0}}, data1};
         if (!multi_start) begin
            result   <= quick_res;
            zero     <= (quick_res == '0);
            carry    <= quick_c;
            overflow <= quick_v;
         end
      end else if (state == RUN) begin
         acc <= acc_step;
         cnt <= cnt - CNT_W'(1);
         if (last_step) begin
            result   <= acc_step[WIDTH-1:0];
            zero     <= (acc_step[WIDTH-1:0] == '0);
            carry    <= 1'b0;
            overflow <= (op_q == OP_MUL) && (|acc_step[2*WIDTH-1:WIDTH]);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] select;
   logic [7:0] data1, data2;
   logic       busy, done, zero, carry, overflow;
   logic [7:0] result;

   int total = 0;
   int bad   = 0;
   int lat;
   int pulses;

   multicycle_alu #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .select   (select),
      .data1    (data1),
      .data2    (data2),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .carry    (carry),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Issue one op, scramble the operand inputs after acceptance, wait for DONE
   // (bounded), then check latency, result and flags.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input int exp_lat, input logic [7:0] exp_res,
                         input logic exp_z, input logic exp_c, input logic exp_v);
      @(negedge clk);
      start = 1'b1; select = op; data1 = a; data2 = b;
      @(posedge clk); #1;
      start = 1'b0; select = ~op; data1 = ~a; data2 = ~b;
      check({tag, "_busy"}, busy, 1);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, result, exp_res);
      check({tag, "_zero"}, zero, exp_z);
      check({tag, "_carry"}, carry, exp_c);
      check({tag, "_ovf"}, overflow, exp_v);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; select = '0; data1 = '0; data2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", result, 0);
      check("rst_flags", {zero, carry, overflow}, 0);
      @(negedge clk); reset = 1'b0;

      // T1/T2: single-cycle arithmetic and logic
      run_op("add_200_100", OP_ADD, 8'd200, 8'd100, 1, 8'h2C, 0, 1, 0);
      run_op("sub_5_5",     OP_SUB, 8'd5,   8'd5,   1, 8'h00, 1, 1, 0);
      run_op("sub_3_5",     OP_SUB, 8'd3,   8'd5,   1, 8'hFE, 0, 0, 0);
      run_op("add_7f_1",    OP_ADD, 8'h7F,  8'h01,  1, 8'h80, 0, 0, 1);
      run_op("sub_80_1",    OP_SUB, 8'h80,  8'h01,  1, 8'h7F, 0, 1, 1);
      run_op("fwd",         OP_FWD, 8'h12,  8'h34,  1, 8'h34, 0, 0, 0);
      run_op("and",         OP_AND, 8'hF0,  8'h3C,  1, 8'h30, 0, 0, 0);
      run_op("or",          OP_OR,  8'hF0,  8'h0C,  1, 8'hFC, 0, 0, 0);

      // T3: shifts
      run_op("sll_81_3",    OP_SLL, 8'h81,  8'd3,   4, 8'h08, 0, 0, 0);
      run_op("sra_80_9",    OP_SRA, 8'h80,  8'd9,   9, 8'hFF, 0, 0, 0);
      run_op("sll_by_0",    OP_SLL, 8'h5A,  8'd0,   1, 8'h5A, 0, 0, 0);
      run_op("sra_40_2",    OP_SRA, 8'h40,  8'd2,   3, 8'h10, 0, 0, 0);
      run_op("sll_ff_200",  OP_SLL, 8'hFF,  8'd200, 9, 8'h00, 1, 0, 0);

      // T4: multiply
      run_op("mul_15_17",   OP_MUL, 8'd15,  8'd17,  9, 8'hFF, 0, 0, 0);
      run_op("mul_16_16",   OP_MUL, 8'd16,  8'd16,  9, 8'h00, 1, 0, 1);
      run_op("mul_13_11",   OP_MUL, 8'd13,  8'd11,  9, 8'h8F, 0, 0, 0);

      // T5a: START pulsed during a MUL is ignored and not queued
      @(posedge clk); #1;
      @(negedge clk);
      start = 1'b1; select = OP_MUL; data1 = 8'd3; data2 = 8'd4;
      @(posedge clk); #1; start = 1'b0; lat = 1;
      @(posedge clk); #1; lat++;
      @(negedge clk);
      start = 1'b1; select = OP_ADD; data1 = 8'd1; data2 = 8'd1;
      @(posedge clk); #1; start = 1'b0; lat++;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("ign_done", done, 1);
      check("ign_lat", lat, 9);
      check("ign_res", result, 12);
      @(posedge clk); #1;
      check("ign_noq_busy", busy, 0);
      check("ign_noq_done", done, 0);

      // T5b: START held through FIN gives back-to-back DONE pulses
      @(negedge clk);
      start = 1'b1; select = OP_ADD; data1 = 8'd1; data2 = 8'd2;
      @(posedge clk); #1;
      check("b2b_first_done", done, 1);
      check("b2b_first_res", result, 3);
      select = OP_SUB; data1 = 8'd9; data2 = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_second_done", done, 1);
      check("b2b_second_res", result, 5);
      check("b2b_second_carry", carry, 1);
      @(posedge clk); #1;
      check("b2b_after_done", done, 0);
      check("b2b_after_busy", busy, 0);

      // T6: reset during MUL cycle 4 aborts it
      @(negedge clk);
      start = 1'b1; select = OP_MUL; data1 = 8'd16; data2 = 8'd16;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_res", result, 0);
      check("abort_flags", {zero, carry, overflow}, 0);
      @(negedge clk); reset = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      check("abort_no_done", pulses, 0);
      check("abort_idle", busy, 0);

      run_op("post_reset_add", OP_ADD, 8'd1, 8'd1, 1, 8'h02, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
